// File: rtl/pio_keys_leds.sv
// pio_keys_leds: Avalon-MM PIO slave with synchronised key inputs, edge capture/IRQ and set/clear LED outputs.
// Optional macro PIO_DEBOUNCE_EN builds per-bit debounce counters; otherwise stable follows sync2 directly.
module pio_keys_leds #(
    parameter int unsigned IN_WIDTH        = 2,
    parameter int unsigned OUT_WIDTH       = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter logic [OUT_WIDTH-1:0] OUT_RESET = '0
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset,
    input  logic [2:0]           avs_address,
    input  logic                 avs_read,
    input  logic                 avs_write,
    input  logic [31:0]          avs_writedata,
    output logic [31:0]          avs_readdata,
    output logic                 irq,
    input  logic [IN_WIDTH-1:0]  keys_export,
    output logic [OUT_WIDTH-1:0] leds_export
);

    typedef enum logic [2:0] {
        A_DATA_IN   = 3'd0,
        A_DATA_OUT  = 3'd1,
        A_IRQ_MASK  = 3'd2,
        A_EDGE_CAP  = 3'd3,
        A_OUT_SET   = 3'd4,
        A_OUT_CLR   = 3'd5,
        A_EDGE_MODE = 3'd6,
        A_RSVD      = 3'd7
    } addr_e;

    logic [IN_WIDTH-1:0]  sync1_q, sync2_q, stable, stable_prev_q;
    logic [IN_WIDTH-1:0]  edge_cap_q, edge_cap_d, cap_clr, edge_hit;
    logic [IN_WIDTH-1:0]  irq_mask_q, irq_mask_d, edge_mode_q, edge_mode_d;
    logic [OUT_WIDTH-1:0] out_q, out_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 unused_wd;

    assign unused_wd = ^avs_writedata;

`ifdef PIO_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic [CNT_W-1:0]    cnt_q [IN_WIDTH];
    logic [CNT_W-1:0]    cnt_d [IN_WIDTH];
    logic [IN_WIDTH-1:0] stable_q, stable_d;

    // A bit is accepted on the DEBOUNCE_CYCLES-th consecutive mismatching sample.
    always_comb begin
        stable_d = stable_q;
        for (int unsigned i = 0; i < IN_WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            stable_q <= '0;
            for (int unsigned i = 0; i < IN_WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            stable_q <= stable_d;
            for (int unsigned i = 0; i < IN_WIDTH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign stable = stable_q;
`else
    localparam int unsigned unused_debounce = DEBOUNCE_CYCLES;

    assign stable = sync2_q;
`endif

    always_comb begin
        rdata_d = rdata_q;
        if (avs_read) begin
            case (addr_e'(avs_address))
                A_DATA_IN:   rdata_d = 32'(stable);
                A_DATA_OUT:  rdata_d = 32'(out_q);
                A_IRQ_MASK:  rdata_d = 32'(irq_mask_q);
                A_EDGE_CAP:  rdata_d = 32'(edge_cap_q);
                A_EDGE_MODE: rdata_d = 32'(edge_mode_q);
                default:     rdata_d = '0;
            endcase
        end
    end

    always_comb begin
        out_d       = out_q;
        irq_mask_d  = irq_mask_q;
        edge_mode_d = edge_mode_q;
        cap_clr     = '0;
        if (avs_write) begin
            case (addr_e'(avs_address))
                A_DATA_OUT:  out_d       = avs_writedata[OUT_WIDTH-1:0];
                A_IRQ_MASK:  irq_mask_d  = avs_writedata[IN_WIDTH-1:0];
                A_EDGE_CAP:  cap_clr     = avs_writedata[IN_WIDTH-1:0];
                A_OUT_SET:   out_d       = out_q | avs_writedata[OUT_WIDTH-1:0];
                A_OUT_CLR:   out_d       = out_q & ~avs_writedata[OUT_WIDTH-1:0];
                A_EDGE_MODE: edge_mode_d = avs_writedata[IN_WIDTH-1:0];
                default: ;
            endcase
        end
        edge_hit   = (stable & ~stable_prev_q & ~edge_mode_q)
                   | (~stable & stable_prev_q & edge_mode_q);
        // New edges are OR-ed in after the clear so a same-cycle set wins.
        edge_cap_d = (edge_cap_q & ~cap_clr) | edge_hit;
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_prev_q <= '0;
            edge_cap_q    <= '0;
            irq_mask_q    <= '0;
            edge_mode_q   <= '0;
            out_q         <= OUT_RESET;
            rdata_q       <= '0;
        end else begin
            sync1_q       <= keys_export;
            sync2_q       <= sync1_q;
            stable_prev_q <= stable;
            edge_cap_q    <= edge_cap_d;
            irq_mask_q    <= irq_mask_d;
            edge_mode_q   <= edge_mode_d;
            out_q         <= out_d;
            rdata_q       <= rdata_d;
        end
    end

    assign avs_readdata = rdata_q;
    assign leds_export  = out_q;
    assign irq          = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_pio_keys_leds.sv
// Self-checking bench for pio_keys_leds: directed register/key scenarios plus random bus and key traffic against a cycle model.
module tb_pio_keys_leds;

    localparam int IW = 2;
    localparam int OW = 8;
    localparam int DC = 4;
    localparam logic [OW-1:0] ORST = '0;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    addr;
    logic          rd, wr;
    logic [31:0]   wd;
    logic [31:0]   rdata;
    logic          irq;
    logic [IW-1:0] keys;
    logic [OW-1:0] leds;

    always #5 clk = ~clk;

    pio_keys_leds #(
        .IN_WIDTH(IW),
        .OUT_WIDTH(OW),
        .DEBOUNCE_CYCLES(DC),
        .OUT_RESET(ORST)
    ) dut (
        .clk_clk(clk),
        .reset_reset(rst),
        .avs_address(addr),
        .avs_read(rd),
        .avs_write(wr),
        .avs_writedata(wd),
        .avs_readdata(rdata),
        .irq(irq),
        .keys_export(keys),
        .leds_export(leds)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    bit [IW-1:0] m_s1, m_s2, m_stab, m_prev, m_cap, m_mask, m_mode;
    bit [OW-1:0] m_out;
    bit [31:0]   m_rd;
    int          run_len [IW];

    function automatic bit [IW-1:0] cur_stable();
`ifdef PIO_DEBOUNCE_EN
        return m_stab;
`else
        return m_s2;
`endif
    endfunction

    function automatic bit [IW-1:0] pend_edges();
        bit [IW-1:0] s;
        s = cur_stable();
        return (s & ~m_prev & ~m_mode) | (~s & m_prev & m_mode);
    endfunction

    function automatic bit [31:0] reg_val(input bit [2:0] a);
        case (a)
            3'd0:    return 32'(cur_stable());
            3'd1:    return 32'(m_out);
            3'd2:    return 32'(m_mask);
            3'd3:    return 32'(m_cap);
            3'd6:    return 32'(m_mode);
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_edge();
        bit [IW-1:0] s_old, hit, cap_n, wdi;
        bit [OW-1:0] wdo;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_stab = '0; m_prev = '0;
            m_cap = '0; m_mask = '0; m_mode = '0; m_rd = '0;
            m_out = ORST;
            for (int i = 0; i < IW; i++) run_len[i] = 0;
            return;
        end
        s_old = cur_stable();
        hit   = pend_edges();
        wdi   = wd[IW-1:0];
        wdo   = wd[OW-1:0];
        if (rd) m_rd = reg_val(addr);
        cap_n = m_cap;
        if (wr) begin
            case (addr)
                3'd1: m_out  = wdo;
                3'd2: m_mask = wdi;
                3'd3: cap_n  = m_cap & ~wdi;
                3'd4: m_out  = m_out | wdo;
                3'd5: m_out  = m_out & ~wdo;
                3'd6: m_mode = wdi;
                default: ;
            endcase
        end
        m_cap = cap_n | hit;
        // stable accepts a level after DC consecutive samples that disagree with it
        for (int i = 0; i < IW; i++) begin
            if (m_s2[i] != m_stab[i]) begin
                run_len[i]++;
                if (run_len[i] == DC) begin
                    m_stab[i]  = m_s2[i];
                    run_len[i] = 0;
                end
            end else begin
                run_len[i] = 0;
            end
        end
        m_prev = s_old;
        m_s2   = m_s1;
        m_s1   = keys;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("leds", 32'(leds), 32'(m_out));
        check("irq", 32'(irq), 32'(|(m_cap & m_mask)));
        check("readdata", rdata, m_rd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus(input logic r, input logic w, input logic [2:0] a, input logic [31:0] d);
        rd = r; wr = w; addr = a; wd = d;
        tick();
        rd = 1'b0; wr = 1'b0;
    endtask

    int          first_irq;
    bit          found;
    bit [IW-1:0] h;

    initial begin
        rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wd = '0; keys = '0;
        for (int i = 0; i < IW; i++) run_len[i] = 0;
        idle(2);
        rst = 1'b0;
        check("rst_leds", 32'(leds), 32'(ORST));
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        for (int a = 0; a < 8; a++) begin
            bus(1'b1, 1'b0, 3'(a), '0);
            check("rst_read", rdata, (a == 1) ? 32'(ORST) : 32'd0);
        end

        bus(1'b0, 1'b1, 3'd1, 32'hFFFF_FFA5);
        check("wr_out", 32'(leds), 32'hA5);
        bus(1'b0, 1'b1, 3'd4, 32'h0000_000F);
        check("out_set", 32'(leds), 32'hAF);
        bus(1'b0, 1'b1, 3'd5, 32'h0000_0081);
        check("out_clr", 32'(leds), 32'h2E);
        bus(1'b1, 1'b0, 3'd1, '0);
        check("rd_out", rdata, 32'h2E);

        // short glitch on key[0]
        keys[0] = 1'b1;
        idle(3);
        keys[0] = 1'b0;
        idle(DC + 6);
        bus(1'b1, 1'b0, 3'd0, '0);
`ifdef PIO_DEBOUNCE_EN
        check("glitch_data_in", rdata, 32'd0);
`endif
        bus(1'b1, 1'b0, 3'd3, '0);
`ifdef PIO_DEBOUNCE_EN
        check("glitch_edge_cap", rdata, 32'd0);
`endif
        bus(1'b0, 1'b1, 3'd3, 32'h3);

        // held key[0]: irq latency and DATA_IN
        bus(1'b0, 1'b1, 3'd2, 32'h1);
        first_irq = 0;
        keys[0] = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            if (i == 8) begin rd = 1'b1; addr = 3'd0; end
            tick();
            if (i == 8) begin
                rd = 1'b0;
                check("held_data_in", rdata, 32'h1);
            end
            if (irq && first_irq == 0) first_irq = i;
            if (i == 10) keys[0] = 1'b0;
        end
`ifdef PIO_DEBOUNCE_EN
        check("irq_latency", 32'(first_irq), 32'(DC + 3));
`else
        check("irq_latency", 32'(first_irq), 32'd3);
`endif
        bus(1'b0, 1'b1, 3'd3, 32'h1);
        bus(1'b0, 1'b1, 3'd2, 32'h0);

        // falling-edge capture on key[1]
        bus(1'b0, 1'b1, 3'd2, 32'h2);
        bus(1'b0, 1'b1, 3'd6, 32'h2);
        keys[1] = 1'b1;
        idle(DC + 6);
        check("rise_ignored_irq", 32'(irq), 32'd0);
        keys[1] = 1'b0;
        idle(DC + 6);
        check("fall_irq", 32'(irq), 32'd1);
        bus(1'b1, 1'b0, 3'd3, '0);
        check("fall_edge_cap", rdata, 32'h2);
        bus(1'b0, 1'b1, 3'd3, 32'h2);
        check("w1c_irq", 32'(irq), 32'd0);

        // edge on key[0] lands in the same cycle as a W1C of bit 0
        found = 1'b0;
        keys[0] = 1'b1;
        for (int i = 0; i < 30 && !found; i++) begin
            h = pend_edges();
            if (h[0]) begin
                bus(1'b0, 1'b1, 3'd3, 32'h1);
                found = 1'b1;
            end else begin
                tick();
            end
        end
        check("race_found", 32'(found), 32'd1);
        bus(1'b1, 1'b0, 3'd3, '0);
        check("set_wins", rdata & 32'h1, 32'h1);

        // reset during a read
        bus(1'b0, 1'b1, 3'd2, 32'h1);
        check("pre_rst_irq", 32'(irq), 32'd1);
        rst = 1'b1; rd = 1'b1; addr = 3'd3;
        tick();
        rst = 1'b0; rd = 1'b0;
        check("midrst_rdata", rdata, 32'd0);
        check("midrst_irq", 32'(irq), 32'd0);
        check("midrst_leds", 32'(leds), 32'(ORST));
        bus(1'b1, 1'b0, 3'd3, '0);
        check("midrst_edge_cap", rdata, 32'd0);

        // random bus and key traffic
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 5) == 0) keys = IW'($urandom);
            rst  = ($urandom_range(0, 199) == 0);
            rd   = 1'($urandom_range(0, 1));
            wr   = 1'($urandom_range(0, 1));
            addr = 3'($urandom_range(0, 7));
            wd   = $urandom;
            tick();
        end
        rst = 1'b0; rd = 1'b0; wr = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
